led_blinker_array: RTL



---
 rtl/led_blinker_array.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_blinker_array.sv
// led_blinker_array: CHANNELS independent LED drivers (OFF/ON/BLINK/PWM_BLINK); `LED_SYNC_EN adds sync_strobe.
// led is registered one cycle after channel state; cfg_ready drops while the addressed channel holds an unapplied write.
module led_blinker_array #(
  parameter int          CHANNELS            = 4,
  parameter int          COUNTER_WIDTH       = 32,
  parameter int          PWM_WIDTH           = 8,
  parameter int unsigned DEFAULT_HALF_PERIOD = 32'd104857600,
  parameter int          CH_W                = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clock_100MHz,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_channel,
  input  logic [1:0]               cfg_mode,
  input  logic [COUNTER_WIDTH-1:0] cfg_half_period,
  input  logic [PWM_WIDTH-1:0]     cfg_duty,
  output logic [CHANNELS-1:0]      led,
  output logic [CHANNELS-1:0]      wrap_pulse
`ifdef LED_SYNC_EN
  ,
  input  logic                     sync_strobe
`endif
);

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_ON        = 2'd1,
    MODE_BLINK     = 2'd2,
    MODE_PWM_BLINK = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                    mode;
    logic [COUNTER_WIDTH-1:0] half_period;
    logic [PWM_WIDTH-1:0]     duty;
  } chan_cfg_t;

  localparam logic [COUNTER_WIDTH-1:0] RESET_HALF_PERIOD = COUNTER_WIDTH'(DEFAULT_HALF_PERIOD);

  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [CHANNELS-1:0]  pending;
  logic [CHANNELS-1:0]  wr_sel;
  logic                 sync;
  chan_cfg_t            wr_cfg;

  assign wr_cfg = '{mode: mode_e'(cfg_mode), half_period: cfg_half_period, duty: cfg_duty};

`ifdef LED_SYNC_EN
  assign sync = sync_strobe;
`else
  assign sync = 1'b0;
`endif

  // Indices with no matching channel keep cfg_ready high and select nothing, so the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wr_sel    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_channel == CH_W'(i)) begin
        cfg_ready = ~pending[i];
        wr_sel[i] = cfg_valid & ~pending[i];
      end
    end
  end

  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam mode_e RESET_MODE = (i == 0) ? MODE_BLINK : MODE_OFF;

    chan_cfg_t                cur;
    chan_cfg_t                shadow;
    logic [COUNTER_WIDTH-1:0] counter;
    logic                     phase;
    logic                     blinking;
    logic                     at_wrap;
    logic                     apply;
    logic                     blink_after;
    logic                     led_next;

    assign blinking = (cur.mode == MODE_BLINK) || (cur.mode == MODE_PWM_BLINK);
    assign at_wrap  = (counter == cur.half_period);
    // New settings land only at a phase boundary (or at once when static) so no phase is ever truncated.
    assign apply    = pending[i] && (!blinking || at_wrap);
    assign blink_after = apply ? ((shadow.mode == MODE_BLINK) || (shadow.mode == MODE_PWM_BLINK))
                               : blinking;

    always_comb begin
      case (cur.mode)
        MODE_ON:        led_next = 1'b1;
        MODE_BLINK:     led_next = phase;
        MODE_PWM_BLINK: led_next = phase & (pwm_cnt < cur.duty);
        default:        led_next = 1'b0;
      endcase
    end

    always_ff @(posedge clock_100MHz or negedge reset_n) begin
      if (!reset_n) begin
        cur           <= '{mode: RESET_MODE, half_period: RESET_HALF_PERIOD, duty: '1};
        shadow        <= '{mode: MODE_OFF, half_period: '0, duty: '0};
        counter       <= '0;
        phase         <= 1'b0;
        pending[i]    <= 1'b0;
        led[i]        <= 1'b0;
        wrap_pulse[i] <= 1'b0;
      end else begin
        led[i] <= led_next;
        if (wr_sel[i]) begin
          shadow     <= wr_cfg;
          pending[i] <= 1'b1;
        end
        if (apply) begin
          cur           <= shadow;
          counter       <= '0;
          phase         <= 1'b0;
          pending[i]    <= 1'b0;
          wrap_pulse[i] <= blinking;
        end else if (blinking) begin
          if (at_wrap) begin
            counter       <= '0;
            phase         <= ~phase;
            wrap_pulse[i] <= 1'b1;
          end else begin
            counter       <= counter + COUNTER_WIDTH'(1);
            wrap_pulse[i] <= 1'b0;
          end
        end else begin
          counter       <= '0;
          phase         <= 1'b0;
          wrap_pulse[i] <= 1'b0;
        end
        // The strobe wins over any coincident wrap; a coincident apply keeps its new config.
        if (sync && blink_after) begin
          counter       <= '0;
          phase         <= 1'b1;
          wrap_pulse[i] <= 1'b0;
        end
      end
    end

    a_counter_bounded: assert property (@(posedge clock_100MHz) disable iff (!reset_n)
      counter <= cur.half_period);
  end

endmodule
